ysyx_24080006_axi_arbiter: RTL and testbench

//  Shares one downstream AXI4 master port between the IFU (read-only) and the LSU (read/write).
//  - Sits between the core fetch/load-store units and the SoC bus / xbar.
//  - Allows one outstanding transaction in total; only the granted master sees handshakes.
//  - Routes all channels through combinationally once a grant is registered.

---
 rtl/ysyx_24080006_axi_arbiter_if.sv | 69 ++++++
 rtl/ysyx_24080006_axi_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ysyx_24080006_axi_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24080006_axi_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_axi
//   Reduced AXI4 bundle shared by the core units, the arbiter and the SoC bus.
//   Widths: 32-bit address/data, 4-bit IDs, single-ID-per-master usage.
//   Modports:
//     master : drives AR/AW/W payload + valids, R/B readies
//     slave  : drives AR/AW/W readies, R/B payload + valids
// ---------------------------------------------------------------------------
interface ysyx_24080006_axi;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );
endinterface

// File: rtl/ysyx_24080006_axi_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_axi_arbiter
//   Shares one downstream AXI4 master port between the IFU (read only) and
//   the LSU (read/write). One transaction in flight at a time; once a grant
//   is registered all channels of the winner are routed combinationally.
//
//   Ports:
//     clock    : the one clock
//     reset    : asynchronous, active-low
//     axi_ifu  : IFU upstream (AR/R used)
//     axi_lsu  : LSU upstream (AR/R/AW/W/B)
//     axi_mem  : shared downstream port
//     busy     : high whenever a transaction is granted
//     grant    : one-hot {lsu, ifu}, zero when idle
//
//   Configuration macro: ARB_ROUND_ROBIN_EN
//     defined   : simultaneous reads go to the master not served last
//     undefined : simultaneous reads go to FIXED_WINNER (1 = LSU, 0 = IFU)
// ---------------------------------------------------------------------------
module ysyx_24080006_axi_arbiter #(
  parameter logic       FIXED_WINNER = 1'b1,
  parameter logic [3:0] IFU_ARID     = 4'h1,
  parameter logic [3:0] LSU_XID      = 4'h0
) (
  input  logic             clock,
  input  logic             reset,
  ysyx_24080006_axi.slave  axi_ifu,
  ysyx_24080006_axi.slave  axi_lsu,
  ysyx_24080006_axi.master axi_mem,
  output logic             busy,
  output logic [1:0]       grant
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IFU_RD = 2'd1,
    S_LSU_RD = 2'd2,
    S_LSU_WR = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_rrLast;   // 0 = IFU served last, 1 = LSU served last
  logic       r_arDone;
  logic       r_awDone;
  logic       r_wDone;
  logic       r_busy;
  logic [1:0] r_grant;

  logic       w_ifuRd;
  logic       w_lsuRd;
  logic       w_lsuWr;
  logic       w_anyRd;
  logic [3:0] w_expRid;
  logic       w_ridOk;
  logic       w_bidOk;
  logic       w_bOpen;
  logic       w_rDone;
  logic       w_pickLsu;
  logic       w_unused;

  assign w_ifuRd  = (r_state == S_IFU_RD);
  assign w_lsuRd  = (r_state == S_LSU_RD);
  assign w_lsuWr  = (r_state == S_LSU_WR);
  assign w_anyRd  = w_ifuRd | w_lsuRd;
  assign w_expRid = w_ifuRd ? IFU_ARID : LSU_XID;
  // Responses carrying a foreign ID are neither forwarded nor accepted.
  assign w_ridOk  = (axi_mem.rid == w_expRid);
  assign w_bidOk  = (axi_mem.bid == LSU_XID);

`ifdef ARB_ROUND_ROBIN_EN
  assign w_pickLsu = ~r_rrLast;
`else
  assign w_pickLsu = FIXED_WINNER;
`endif

  // AR: a per-transaction done flag stops a still-high upstream arvalid from
  // issuing a second request while we wait for R.
  assign axi_mem.arvalid = ~r_arDone & ((w_ifuRd & axi_ifu.arvalid) | (w_lsuRd & axi_lsu.arvalid));
  assign axi_mem.araddr  = w_ifuRd ? axi_ifu.araddr  : axi_lsu.araddr;
  assign axi_mem.arlen   = w_ifuRd ? axi_ifu.arlen   : axi_lsu.arlen;
  assign axi_mem.arsize  = w_ifuRd ? axi_ifu.arsize  : axi_lsu.arsize;
  assign axi_mem.arburst = w_ifuRd ? axi_ifu.arburst : axi_lsu.arburst;
  assign axi_mem.arid    = w_ifuRd ? IFU_ARID : LSU_XID;
  assign axi_ifu.arready = w_ifuRd & ~r_arDone & axi_mem.arready;
  assign axi_lsu.arready = w_lsuRd & ~r_arDone & axi_mem.arready;

  // R
  assign axi_mem.rready = w_ridOk & ((w_ifuRd & axi_ifu.rready) | (w_lsuRd & axi_lsu.rready));
  assign axi_ifu.rvalid = w_ifuRd & w_ridOk & axi_mem.rvalid;
  assign axi_lsu.rvalid = w_lsuRd & w_ridOk & axi_mem.rvalid;
  assign axi_ifu.rdata  = w_ifuRd ? axi_mem.rdata : 32'd0;
  assign axi_lsu.rdata  = w_lsuRd ? axi_mem.rdata : 32'd0;
  assign axi_ifu.rresp  = w_ifuRd ? axi_mem.rresp : 2'd0;
  assign axi_lsu.rresp  = w_lsuRd ? axi_mem.rresp : 2'd0;
  assign axi_ifu.rlast  = w_ifuRd & axi_mem.rlast;
  assign axi_lsu.rlast  = w_lsuRd & axi_mem.rlast;
  assign axi_ifu.rid    = w_ifuRd ? axi_mem.rid : 4'd0;
  assign axi_lsu.rid    = w_lsuRd ? axi_mem.rid : 4'd0;
  assign w_rDone        = w_anyRd & axi_mem.rvalid & axi_mem.rready & axi_mem.rlast;

  // AW / W run independently; each closes after its own handshake.
  assign axi_mem.awvalid = w_lsuWr & ~r_awDone & axi_lsu.awvalid;
  assign axi_mem.awaddr  = axi_lsu.awaddr;
  assign axi_mem.awlen   = axi_lsu.awlen;
  assign axi_mem.awsize  = axi_lsu.awsize;
  assign axi_mem.awburst = axi_lsu.awburst;
  assign axi_mem.awid    = LSU_XID;
  assign axi_lsu.awready = w_lsuWr & ~r_awDone & axi_mem.awready;

  assign axi_mem.wvalid  = w_lsuWr & ~r_wDone & axi_lsu.wvalid;
  assign axi_mem.wdata   = axi_lsu.wdata;
  assign axi_mem.wstrb   = axi_lsu.wstrb;
  assign axi_mem.wlast   = axi_lsu.wlast;
  assign axi_lsu.wready  = w_lsuWr & ~r_wDone & axi_mem.wready;

  // B opens only once both AW and W have been accepted.
  assign w_bOpen         = w_lsuWr & r_awDone & r_wDone & w_bidOk;
  assign axi_mem.bready  = w_bOpen & axi_lsu.bready;
  assign axi_lsu.bvalid  = w_bOpen & axi_mem.bvalid;
  assign axi_lsu.bresp   = w_lsuWr ? axi_mem.bresp : 2'd0;
  assign axi_lsu.bid     = w_lsuWr ? axi_mem.bid : 4'd0;

  // The IFU has no write side.
  assign axi_ifu.awready = 1'b0;
  assign axi_ifu.wready  = 1'b0;
  assign axi_ifu.bvalid  = 1'b0;
  assign axi_ifu.bresp   = 2'd0;
  assign axi_ifu.bid     = 4'd0;

  assign busy  = r_busy;
  assign grant = r_grant;

  assign w_unused = ^{axi_ifu.awvalid, axi_ifu.awaddr, axi_ifu.awid, axi_ifu.awlen,
                      axi_ifu.awsize, axi_ifu.awburst, axi_ifu.wvalid, axi_ifu.wdata,
                      axi_ifu.wstrb, axi_ifu.wlast, axi_ifu.bready, axi_ifu.arid,
                      axi_lsu.arid, axi_lsu.awid, r_rrLast};

  // Arbitration happens only in IDLE; writes win over reads, read ties go to
  // the tie-break. busy/grant are registered alongside the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_rrLast <= 1'b0;
      r_arDone <= 1'b0;
      r_awDone <= 1'b0;
      r_wDone  <= 1'b0;
      r_busy   <= 1'b0;
      r_grant  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (axi_lsu.awvalid | axi_lsu.wvalid) begin
            r_state <= S_LSU_WR;
            r_busy  <= 1'b1;
            r_grant <= 2'b10;
          end else if (axi_lsu.arvalid & (~axi_ifu.arvalid | w_pickLsu)) begin
            r_state <= S_LSU_RD;
            r_busy  <= 1'b1;
            r_grant <= 2'b10;
          end else if (axi_ifu.arvalid) begin
            r_state <= S_IFU_RD;
            r_busy  <= 1'b1;
            r_grant <= 2'b01;
          end
        end
        S_IFU_RD, S_LSU_RD: begin
          if (axi_mem.arvalid & axi_mem.arready) r_arDone <= 1'b1;
          if (w_rDone) begin
            r_state  <= S_IDLE;
            r_rrLast <= w_lsuRd;
            r_arDone <= 1'b0;
            r_busy   <= 1'b0;
            r_grant  <= 2'b00;
          end
        end
        S_LSU_WR: begin
          if (axi_mem.awvalid & axi_mem.awready) r_awDone <= 1'b1;
          if (axi_mem.wvalid & axi_mem.wready & axi_mem.wlast) r_wDone <= 1'b1;
          if (axi_mem.bvalid & axi_mem.bready) begin
            r_state  <= S_IDLE;
            r_awDone <= 1'b0;
            r_wDone  <= 1'b0;
            r_busy   <= 1'b0;
            r_grant  <= 2'b00;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_axi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24080006_axi_arbiter
//   Drives both upstream masters and plays the downstream slave. Upstream
//   R/B handshakes are compared against a queue of expected responses that
//   is filled whenever the bench's slave model issues a response.
// ---------------------------------------------------------------------------
module tb_ysyx_24080006_axi_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       busy;
  logic [1:0] grant;

  always #5 clock = ~clock;

  ysyx_24080006_axi ifu ();
  ysyx_24080006_axi lsu ();
  ysyx_24080006_axi mem ();

  ysyx_24080006_axi_arbiter dut (
    .clock   (clock),
    .reset   (reset),
    .axi_ifu (ifu),
    .axi_lsu (lsu),
    .axi_mem (mem),
    .busy    (busy),
    .grant   (grant)
  );

  // dest: 0 = IFU read, 1 = LSU read, 2 = LSU write response
  typedef struct {
    int          dest;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  typedef struct {
    bit         ifuAr;
    bit         lsuAr;
    bit         lsuAw;
    bit         lsuW;
    logic [1:0] expGrant;
    int         kind;     // 0 none, 1 IFU read, 2 LSU read, 3 LSU write
  } vec_t;

  exp_t sbQ[$];
  vec_t vecs[7];
  int   total = 0;
  int   bad = 0;
  int   busyCycles = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResp(input int dest, input logic [31:0] data, input logic [1:0] resp);
    exp_t e;
    if (sbQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected_resp: got response on dest %0d, expected none", dest);
    end else begin
      e = sbQ.pop_front();
      checkOutput("resp_dest", dest, e.dest);
      if (dest != 2) checkOutput("resp_data", data, e.data);
      checkOutput("resp_code", {30'd0, resp}, {30'd0, e.resp});
    end
  endtask

  // Upstream response monitor, sampled on the inactive edge.
  always @(negedge clock) begin
    if (busy === 1'b1) busyCycles++;
    if (ifu.rvalid === 1'b1 && ifu.rready === 1'b1) checkResp(0, ifu.rdata, ifu.rresp);
    if (lsu.rvalid === 1'b1 && lsu.rready === 1'b1) checkResp(1, lsu.rdata, lsu.rresp);
    if (lsu.bvalid === 1'b1 && lsu.bready === 1'b1) checkResp(2, 32'd0, lsu.bresp);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    ifu.arvalid = 1'b0; ifu.araddr = 32'd0; ifu.arid = 4'd0; ifu.arlen = 8'd0;
    ifu.arsize = 3'd2;  ifu.arburst = 2'd1; ifu.rready = 1'b1;
    ifu.awvalid = 1'b0; ifu.awaddr = 32'd0; ifu.awid = 4'd0; ifu.awlen = 8'd0;
    ifu.awsize = 3'd2;  ifu.awburst = 2'd1; ifu.wvalid = 1'b0; ifu.wdata = 32'd0;
    ifu.wstrb = 4'd0;   ifu.wlast = 1'b1;   ifu.bready = 1'b1;
    lsu.arvalid = 1'b0; lsu.araddr = 32'd0; lsu.arid = 4'd0; lsu.arlen = 8'd0;
    lsu.arsize = 3'd2;  lsu.arburst = 2'd1; lsu.rready = 1'b1;
    lsu.awvalid = 1'b0; lsu.awaddr = 32'd0; lsu.awid = 4'd0; lsu.awlen = 8'd0;
    lsu.awsize = 3'd2;  lsu.awburst = 2'd1; lsu.wvalid = 1'b0; lsu.wdata = 32'd0;
    lsu.wstrb = 4'd0;   lsu.wlast = 1'b1;   lsu.bready = 1'b1;
    mem.arready = 1'b0; mem.rvalid = 1'b0; mem.rdata = 32'd0; mem.rresp = 2'd0;
    mem.rlast = 1'b0;   mem.rid = 4'd0;    mem.awready = 1'b0; mem.wready = 1'b0;
    mem.bvalid = 1'b0;  mem.bresp = 2'd0;  mem.bid = 4'd0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    idleInputs();
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  // Serve a granted read: AR accepted at once, R after waitCycles more.
  task automatic readTxn(input bit isLsu, input logic [31:0] data, input logic [1:0] resp,
                         input int waitCycles, input bit badIdFirst);
    exp_t       e;
    logic [3:0] id;
    id = isLsu ? 4'h0 : 4'h1;
    mem.arready = 1'b1;
    #1;
    checkOutput("arid", {28'd0, mem.arid}, {28'd0, id});
    checkOutput("arready_granted", isLsu ? lsu.arready : ifu.arready, 1);
    checkOutput("arready_other", isLsu ? ifu.arready : lsu.arready, 0);
    tick();
    mem.arready = 1'b0;
    if (isLsu) lsu.arvalid = 1'b0; else ifu.arvalid = 1'b0;
    repeat (waitCycles) tick();
    if (badIdFirst) begin
      mem.rvalid = 1'b1; mem.rid = ~id; mem.rlast = 1'b1; mem.rdata = 32'h0BAD_0BAD;
      #1;
      checkOutput("rvalid_badid", isLsu ? lsu.rvalid : ifu.rvalid, 0);
      checkOutput("rready_badid", mem.rready, 0);
      tick();
      checkOutput("busy_badid", busy, 1);
    end
    mem.rvalid = 1'b1; mem.rid = id; mem.rlast = 1'b1; mem.rdata = data; mem.rresp = resp;
    e.dest = isLsu ? 1 : 0; e.data = data; e.resp = resp;
    sbQ.push_back(e);
    #1;
    checkOutput("rvalid_other", isLsu ? ifu.rvalid : lsu.rvalid, 0);
    tick();
    mem.rvalid = 1'b0; mem.rlast = 1'b0; mem.rresp = 2'd0;
    checkOutput("busy_after_rd", busy, 0);
    checkOutput("grant_after_rd", {30'd0, grant}, 0);
  endtask

  // Serve a granted write: AW now, W two cycles later, B held early by the slave.
  task automatic writeTxn(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp);
    exp_t e;
    lsu.awvalid = 1'b1; lsu.awaddr = addr; lsu.wvalid = 1'b1; lsu.wdata = data;
    lsu.wstrb = strb;   lsu.wlast = 1'b1;
    mem.awready = 1'b1; mem.bvalid = 1'b1; mem.bid = 4'h0; mem.bresp = resp;
    #1;
    checkOutput("awid", {28'd0, mem.awid}, 0);
    checkOutput("awaddr", mem.awaddr, addr);
    checkOutput("awready_up", lsu.awready, 1);
    checkOutput("wready_early", lsu.wready, 0);
    checkOutput("bvalid_early", lsu.bvalid, 0);
    checkOutput("bready_early", mem.bready, 0);
    tick();
    mem.awready = 1'b0;
    #1;
    checkOutput("awvalid_after_done", mem.awvalid, 0);
    checkOutput("bvalid_aw_only", lsu.bvalid, 0);
    lsu.awvalid = 1'b0;
    tick();
    mem.wready = 1'b1;
    #1;
    checkOutput("wvalid_down", mem.wvalid, 1);
    checkOutput("wdata_down", mem.wdata, data);
    checkOutput("wstrb_down", {28'd0, mem.wstrb}, {28'd0, strb});
    checkOutput("wready_up", lsu.wready, 1);
    tick();
    mem.wready = 1'b0;
    lsu.wvalid = 1'b0;
    e.dest = 2; e.data = 32'd0; e.resp = resp;
    sbQ.push_back(e);
    #1;
    checkOutput("bvalid_up", lsu.bvalid, 1);
    checkOutput("bready_down", mem.bready, 1);
    checkOutput("busy_wr", busy, 1);
    tick();
    mem.bvalid = 1'b0;
    checkOutput("busy_after_wr", busy, 0);
    checkOutput("grant_after_wr", {30'd0, grant}, 0);
  endtask

  // Present one table vector in IDLE and check arbitration and completion.
  task automatic applyStimulus(input vec_t v);
    ifu.arvalid = v.ifuAr; ifu.araddr = 32'h3000_0100;
    lsu.arvalid = v.lsuAr; lsu.araddr = 32'h8000_0200;
    lsu.awvalid = v.lsuAw; lsu.awaddr = 32'h8000_0300;
    lsu.wvalid  = v.lsuW;  lsu.wdata  = 32'h1234_5678; lsu.wstrb = 4'hF;
    mem.arready = 1'b1; mem.awready = 1'b1; mem.wready = 1'b1;
    #1;
    checkOutput("idle_ifu_arready", ifu.arready, 0);
    checkOutput("idle_lsu_arready", lsu.arready, 0);
    checkOutput("idle_lsu_awready", lsu.awready, 0);
    checkOutput("idle_lsu_wready", lsu.wready, 0);
    checkOutput("idle_mem_arvalid", mem.arvalid, 0);
    mem.arready = 1'b0; mem.awready = 1'b0; mem.wready = 1'b0;
    tick();
    checkOutput("vec_grant", {30'd0, grant}, {30'd0, v.expGrant});
    checkOutput("vec_busy", busy, (v.kind != 0) ? 1 : 0);
    if (v.kind == 3 && v.ifuAr) checkOutput("ifu_stalled_arready", ifu.arready, 0);
    if (v.kind == 3) begin
      ifu.arvalid = 1'b0;
      lsu.arvalid = 1'b0;
    end
    case (v.kind)
      1: readTxn(1'b0, $urandom, 2'b00, 1, 1'b0);
      2: readTxn(1'b1, $urandom, 2'b00, 2, 1'b0);
      3: writeTxn(32'h8000_0300, $urandom, 4'hF, 2'b00);
      default: tick();
    endcase
  endtask

  initial begin
    bit expLsu;

    vecs[0] = '{0, 0, 0, 0, 2'b00, 0};
    vecs[1] = '{1, 0, 0, 0, 2'b01, 1};
    vecs[2] = '{0, 1, 0, 0, 2'b10, 2};
    vecs[3] = '{0, 0, 1, 1, 2'b10, 3};
    vecs[4] = '{0, 0, 0, 1, 2'b10, 3};
    vecs[5] = '{1, 0, 1, 1, 2'b10, 3};
    vecs[6] = '{0, 1, 1, 1, 2'b10, 3};

    // Reset state, with upstream valids pushing.
    reset = 1'b0;
    idleInputs();
    ifu.arvalid = 1'b1;
    lsu.awvalid = 1'b1;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant", {30'd0, grant}, 0);
    checkOutput("rst_mem_arvalid", mem.arvalid, 0);
    checkOutput("rst_mem_awvalid", mem.awvalid, 0);
    checkOutput("rst_mem_wvalid", mem.wvalid, 0);
    doReset();

    // IFU fetch alone.
    $display("[TB] IFU fetch");
    ifu.arvalid = 1'b1; ifu.araddr = 32'h3000_0000;
    busyCycles = 0;
    tick();
    checkOutput("t1_grant", {30'd0, grant}, 1);
    checkOutput("t1_araddr", mem.araddr, 32'h3000_0000);
    readTxn(1'b0, 32'h0000_0413, 2'b00, 3, 1'b0);
    checkOutput("t1_busy_cycles", busyCycles, 5);

    // LSU store word.
    $display("[TB] LSU store");
    lsu.awvalid = 1'b1; lsu.wvalid = 1'b1;
    tick();
    checkOutput("t2_grant", {30'd0, grant}, 2);
    writeTxn(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00);

    // Table of single-shot arbitration cases.
    $display("[TB] arbitration table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
    end

    // Sustained read contention: three rounds, then the loser must still be served.
    $display("[TB] read contention");
    doReset();
    ifu.arvalid = 1'b1; ifu.araddr = 32'h3000_0040;
    lsu.arvalid = 1'b1; lsu.araddr = 32'h8000_0040;
    for (int r = 0; r < 3; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
      expLsu = ((r % 2) == 0);
`else
      expLsu = 1'b1;
`endif
      tick();
      checkOutput("t3_grant", {30'd0, grant}, expLsu ? 2 : 1);
      readTxn(expLsu, 32'hA000_0000 + r, 2'b00, 0, 1'b0);
      if (expLsu) lsu.arvalid = 1'b1; else ifu.arvalid = 1'b1;
    end
    lsu.arvalid = 1'b0;
    ifu.arvalid = 1'b1;
    tick();
    checkOutput("t3_late_ifu_grant", {30'd0, grant}, 1);
    readTxn(1'b0, 32'hA000_00FF, 2'b00, 0, 1'b0);

    // LSU write and read pending together: write first, then read.
    $display("[TB] write before read");
    lsu.arvalid = 1'b1; lsu.araddr = 32'h8000_0080;
    lsu.awvalid = 1'b1; lsu.wvalid = 1'b1;
    tick();
    checkOutput("t4_first_grant", {30'd0, grant}, 2);
    checkOutput("t4_no_ar", mem.arvalid, 0);
    writeTxn(32'h8000_0080, 32'h5555_AAAA, 4'h3, 2'b00);
    tick();
    checkOutput("t4_second_grant", {30'd0, grant}, 2);
    checkOutput("t4_ar_down", mem.arvalid, 1);
    readTxn(1'b1, 32'h0000_7777, 2'b00, 1, 1'b0);

    // Reset while IFU waits for R.
    $display("[TB] reset mid transaction");
    ifu.arvalid = 1'b1; ifu.araddr = 32'h3000_0008;
    tick();
    mem.arready = 1'b1;
    tick();
    mem.arready = 1'b0;
    tick();
    mem.rvalid = 1'b1; mem.rid = 4'h1; mem.rlast = 1'b1; mem.rdata = 32'h1111_2222;
    reset = 1'b0;
    #1;
    checkOutput("t5_grant", {30'd0, grant}, 0);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_mem_arvalid", mem.arvalid, 0);
    checkOutput("t5_ifu_rvalid", ifu.rvalid, 0);
    checkOutput("t5_mem_rready", mem.rready, 0);
    tick();
    mem.rvalid = 1'b0; mem.rlast = 1'b0;
    reset = 1'b1;
    tick();
    checkOutput("t5_regrant", {30'd0, grant}, 1);
    readTxn(1'b0, 32'h0000_0513, 2'b00, 2, 1'b0);

    // LSU byte load returning SLVERR, preceded by a foreign-ID beat.
    $display("[TB] error response");
    lsu.arvalid = 1'b1; lsu.araddr = 32'h0F00_0001; lsu.arsize = 3'd0;
    tick();
    checkOutput("t6_grant", {30'd0, grant}, 2);
    checkOutput("t6_araddr", mem.araddr, 32'h0F00_0001);
    readTxn(1'b1, 32'h0000_00EF, 2'b10, 1, 1'b1);

    repeat (2) tick();
    checkOutput("sb_empty", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
